// File: rtl/imem_access_ctrl.sv
// Single-port 64K x 16 instruction memory arbiter: CPU fetch (read) vs loader (write), BOOT/RUN/DRAIN phases.
// Optional write protection of the low boot region after BOOT: define IMEM_WRITE_PROTECT_EN.
module imem_access_ctrl #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned PROTECT_LIMIT = 32'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  input  logic              boot_req,
  output logic              boot_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned DW = $clog2(STARVE_LIMIT + 1);
  localparam logic [DW-1:0]   DEFER_MAX = DW'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t            state;
  logic [DW-1:0]     defer_cnt;
  logic [DATA_W-1:0] instr_q;
  logic              forced;
  logic              prot;
  logic              wr_en;

  always_comb begin
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    forced    = 1'b0;
    case (state)
      BOOT:  ld_ready = ld_valid;
      RUN: begin
        forced    = ld_valid && (defer_cnt == DEFER_MAX);
        fetch_gnt = fetch_req & ~forced;
        ld_ready  = ld_valid & ~fetch_gnt;
      end
      DRAIN: ld_ready = ld_valid;
      default: ;
    endcase
  end

`ifdef IMEM_WRITE_PROTECT_EN
  localparam logic [ADDR_W-1:0] PROT_A = PROTECT_LIMIT[ADDR_W-1:0];
  // Protected writes still complete the handshake so the loader never stalls on them.
  assign prot = (state != BOOT) && (ld_addr < PROT_A);
`else
  assign prot = 1'b0;
`endif

  assign wr_en     = ld_ready & ~prot;
  assign mem_we    = wr_en;
  assign mem_addr  = fetch_gnt ? fetch_addr : (ld_ready ? ld_addr : '0);
  assign mem_wdata = ld_ready ? ld_data : '0;

  // The memory output register already provides the one-cycle latency; instr_q only holds it afterwards.
  assign fetch_instr = fetch_valid ? mem_rdata : instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      boot_busy   <= 1'b1;
      fetch_valid <= 1'b0;
      instr_q     <= '0;
      ld_count    <= '0;
      ld_err      <= 1'b0;
      defer_cnt   <= '0;
    end else begin
      fetch_valid <= fetch_gnt;
      if (fetch_valid) instr_q <= mem_rdata;
      ld_err <= ld_ready & prot;
      if (wr_en && ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
      if (state == RUN && ld_valid && !ld_ready) defer_cnt <= defer_cnt + 1'b1;
      else                                       defer_cnt <= '0;
      case (state)
        BOOT: if (ld_done) begin
          state     <= RUN;
          boot_busy <= 1'b0;
        end
        RUN: if (boot_req) begin
          boot_busy <= 1'b1;
          if (fetch_gnt) state <= DRAIN;
          else begin
            state    <= BOOT;
            ld_count <= '0;
          end
        end
        DRAIN: begin
          state    <= BOOT;
          ld_count <= '0;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a write-first synchronous 64K x 16 memory model.
module tb_imem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt, fetch_valid;
  logic [15:0] fetch_instr;
  logic        ld_valid;
  logic [15:0] ld_addr, ld_data;
  logic        ld_ready, ld_done, boot_req, boot_busy;
  logic [16:0] ld_count;
  logic        ld_err;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt;

`ifdef IMEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  imem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .boot_req(boot_req), .boot_busy(boot_busy),
    .ld_count(ld_count), .ld_err(ld_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; combinational outputs are sampled 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    rst = 1'b1; fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    ld_done = 0; boot_req = 0;
    tick(); tick();
    chk("rst_boot_busy", 32'(boot_busy), 1);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_fetch_instr", 32'(fetch_instr), 0);
    chk("rst_ld_count", 32'(ld_count), 0);
    chk("rst_ld_err", 32'(ld_err), 0);
    rst = 1'b0;

    // Fetch is locked out during BOOT
    fetch_req = 1; fetch_addr = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      #1 chk("boot_no_gnt", 32'(fetch_gnt), 0);
      tick();
      chk("boot_no_valid", 32'(fetch_valid), 0);
    end
    fetch_req = 0;

    // Boot load of two words
    ld_valid = 1; ld_addr = 16'h0000; ld_data = 16'h1234;
    #1 chk("boot_ld_ready", 32'(ld_ready), 1);
    chk("boot_mem_we", 32'(mem_we), 1);
    tick();
    ld_addr = 16'h0001; ld_data = 16'hABCD; ld_done = 1;
    #1 chk("boot_ld_ready2", 32'(ld_ready), 1);
    chk("boot_mem_addr", 32'(mem_addr), 32'h0001);
    tick();
    ld_valid = 0; ld_done = 0;
    chk("boot_ld_count", 32'(ld_count), 2);
    chk("run_boot_busy", 32'(boot_busy), 0);

    // Back-to-back fetches
    fetch_req = 1; fetch_addr = 16'h0000;
    #1 chk("run_gnt0", 32'(fetch_gnt), 1);
    tick();
    fetch_addr = 16'h0001;
    chk("f0_valid", 32'(fetch_valid), 1);
    chk("f0_instr", 32'(fetch_instr), 32'h1234);
    #1 chk("run_gnt1", 32'(fetch_gnt), 1);
    tick();
    fetch_req = 0;
    chk("f1_valid", 32'(fetch_valid), 1);
    chk("f1_instr", 32'(fetch_instr), 32'hABCD);
    tick();
    chk("f_idle_valid", 32'(fetch_valid), 0);
    chk("f_hold_instr", 32'(fetch_instr), 32'hABCD);

    // Anti-starvation: loader forced in every 5th cycle
    fetch_req = 1; fetch_addr = 16'h0000;
    ld_valid = 1; ld_addr = 16'h0300; ld_data = 16'h5A5A;
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk("starve_ld_ready", 32'(ld_ready), (k % 5 == 0) ? 1 : 0);
      chk("starve_fetch_gnt", 32'(fetch_gnt), (k % 5 == 0) ? 0 : 1);
      tick();
    end
    ld_valid = 0; fetch_req = 0;
    chk("starve_ld_count", 32'(ld_count), 4);
    fetch_req = 1; fetch_addr = 16'h0300;
    tick();
    fetch_req = 0;
    chk("starve_rd", 32'(fetch_instr), 32'h5A5A);
    tick();

    // Write protection (or not) in RUN
    exp_cnt = PROT ? 4 : 5;
    ld_valid = 1; ld_addr = 16'h0010; ld_data = 16'hDEAD;
    #1 chk("prot_ld_ready", 32'(ld_ready), 1);
    chk("prot_mem_we", 32'(mem_we), PROT ? 0 : 1);
    tick();
    ld_valid = 0;
    chk("prot_ld_err", 32'(ld_err), PROT ? 1 : 0);
    chk("prot_ld_count", 32'(ld_count), 32'(exp_cnt));
    tick();
    chk("prot_ld_err_pulse", 32'(ld_err), 0);
    ld_valid = 1; ld_addr = 16'h0200; ld_data = 16'hBEEF;
    #1 chk("unprot_mem_we", 32'(mem_we), 1);
    tick();
    ld_valid = 0;
    chk("unprot_ld_count", 32'(ld_count), 32'(exp_cnt + 1));
    fetch_req = 1; fetch_addr = 16'h0010;
    tick();
    fetch_addr = 16'h0200;
    chk("prot_rd", 32'(fetch_instr), PROT ? 0 : 32'hDEAD);
    tick();
    fetch_req = 0;
    chk("unprot_rd", 32'(fetch_instr), 32'hBEEF);
    tick();

    // boot_req with a fetch in flight goes through DRAIN
    fetch_req = 1; fetch_addr = 16'h0001; boot_req = 1;
    #1 chk("drain_gnt", 32'(fetch_gnt), 1);
    tick();
    boot_req = 0;
    chk("drain_valid", 32'(fetch_valid), 1);
    chk("drain_instr", 32'(fetch_instr), 32'hABCD);
    chk("drain_busy", 32'(boot_busy), 1);
    #1 chk("drain_no_gnt", 32'(fetch_gnt), 0);
    tick();
    chk("reboot_valid", 32'(fetch_valid), 0);
    chk("reboot_busy", 32'(boot_busy), 1);
    chk("reboot_ld_count", 32'(ld_count), 0);

    // Reset while a fetch is granted drops it
    fetch_req = 0; ld_done = 1;
    tick();
    ld_done = 0;
    chk("rerun_busy", 32'(boot_busy), 0);
    fetch_req = 1; fetch_addr = 16'h0000;
    #1 chk("rst_fetch_gnt", 32'(fetch_gnt), 1);
    rst = 1;
    tick();
    rst = 0; fetch_req = 0;
    chk("rst_drop_valid", 32'(fetch_valid), 0);
    chk("rst_busy", 32'(boot_busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
